// File: rtl/pattern_loader_if.sv
// Bus bundle between pattern_loader, the patterns ROM and the life grid.
// The mirror signal exists only when PATTERN_MIRROR_EN is defined.
interface pattern_loader_if #(
    parameter int ROW_W    = 128,
    parameter int ADDR_W   = 10,
    parameter int ROW_BITS = 7,
    parameter int PAT_BITS = 3
);
    logic                start;
    logic [PAT_BITS-1:0] pat_sel;
`ifdef PATTERN_MIRROR_EN
    logic                mirror;
`endif
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ROW_W-1:0]    rom_dout;
    logic                grid_we;
    logic [ROW_BITS-1:0] grid_row;
    logic [ROW_W-1:0]    grid_data;

    modport master (
        input  start,
`ifdef PATTERN_MIRROR_EN
        input  mirror,
`endif
        input  pat_sel,
        input  rom_dout,
        output busy,
        output done,
        output rom_addr,
        output grid_we,
        output grid_row,
        output grid_data
    );

    modport slave (
        output start,
`ifdef PATTERN_MIRROR_EN
        output mirror,
`endif
        output pat_sel,
        output rom_dout,
        input  busy,
        input  done,
        input  rom_addr,
        input  grid_we,
        input  grid_row,
        input  grid_data
    );
endinterface

// File: rtl/pattern_loader.sv
// Copies one 128-row seed pattern from the patterns ROM into the grid.
// Define PATTERN_MIRROR_EN to add a horizontal-flip option (mirror input).
module pattern_loader #(
    parameter int ROW_W    = 128,
    parameter int ADDR_W   = 10,
    parameter int ROW_BITS = 7,
    parameter int PAT_BITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    pattern_loader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t              state;
    logic [PAT_BITS-1:0] pat_q;
    logic [ROW_BITS-1:0] cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [ROW_BITS-1:0] row_q;
    logic                busy_q;
    logic                done_q;
    logic                we_q;
    logic [ROW_W-1:0]    word;
`ifdef PATTERN_MIRROR_EN
    logic                mir_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pat_q  <= '0;
            cnt    <= '0;
            addr_q <= '0;
            row_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            we_q   <= 1'b0;
`ifdef PATTERN_MIRROR_EN
            mir_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_q  <= bus.pat_sel;
                        addr_q <= {bus.pat_sel, {ROW_BITS{1'b0}}};
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef PATTERN_MIRROR_EN
                        mir_q  <= bus.mirror;
`endif
                        state  <= FILL;
                    end
                end
                FILL: begin
                    // ROM data for row cnt arrives one cycle after its address
                    we_q  <= 1'b1;
                    row_q <= cnt;
                    if (cnt != {ROW_BITS{1'b1}}) begin
                        cnt    <= cnt + 1'b1;
                        addr_q <= {pat_q, ROW_BITS'(cnt + 1'b1)};
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign word = bus.rom_dout;

`ifdef PATTERN_MIRROR_EN
    always_comb begin
        bus.grid_data = word;
        if (mir_q) begin
            for (int i = 0; i < ROW_W; i++)
                bus.grid_data[i] = word[ROW_W-1-i];
        end
    end
`else
    assign bus.grid_data = word;
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rom_addr = addr_q;
    assign bus.grid_we  = we_q;
    assign bus.grid_row = row_q;
endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: timeline model of each accepted load,
// ROM and grid memory models, directed loads and literal spot checks.
module tb_pattern_loader;
    localparam int ROW_W    = 128;
    localparam int ADDR_W   = 10;
    localparam int ROW_BITS = 7;
    localparam int PAT_BITS = 3;
    localparam int NONE     = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pattern_loader_if #(
        .ROW_W(ROW_W), .ADDR_W(ADDR_W),
        .ROW_BITS(ROW_BITS), .PAT_BITS(PAT_BITS)
    ) bus ();

    pattern_loader #(
        .ROW_W(ROW_W), .ADDR_W(ADDR_W),
        .ROW_BITS(ROW_BITS), .PAT_BITS(PAT_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // patterns ROM: word[a] = a, registered read
    always @(posedge clk) bus.rom_dout <= {118'b0, bus.rom_addr};

    logic [127:0] grid [128];
    always @(posedge clk)
        if (bus.grid_we === 1'b1) grid[bus.grid_row] <= bus.grid_data;

    function automatic logic [127:0] exp_word(int a, logic mir);
        logic [127:0] w, r;
        w = {118'b0, 10'(a)};
        for (int i = 0; i < 128; i++) r[i] = w[127-i];
        return mir ? r : w;
    endfunction

    // j = edges since the accepted start edge of the current load
    int          j = NONE;
    int          m_pat = 0;
    logic        m_mir = 1'b0;
    int          m_addr = 0;
    int          start_cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            j = NONE;
            m_addr = 0;
        end else begin
            cyc++;
            if (j >= 129 && bus.start === 1'b1) begin
                j = 0;
                m_pat = int'(bus.pat_sel);
`ifdef PATTERN_MIRROR_EN
                m_mir = bus.mirror;
`endif
                start_cyc = cyc;
            end else if (j < NONE) begin
                j++;
            end
            if (j <= 127) m_addr = m_pat * 128 + j;
        end
    end

    int busy_cnt, we_cnt, done_cnt, done_cyc;
    int first_we[$];

    always @(negedge clk) begin
        chk("busy", bus.busy, j <= 128);
        chk("done", bus.done, j == 129);
        chk("grid_we", bus.grid_we, j >= 1 && j <= 128);
        chk("rom_addr", bus.rom_addr, m_addr);
        if (j >= 1 && j <= 128) begin
            chk("grid_row", bus.grid_row, j - 1);
            chk("grid_data", bus.grid_data,
                exp_word(m_pat * 128 + j - 1, m_mir));
        end
        busy_cnt += int'(bus.busy);
        we_cnt   += int'(bus.grid_we);
        done_cnt += int'(bus.done);
        if (bus.done === 1'b1) done_cyc = cyc;
        if (bus.grid_we === 1'b1 && bus.grid_row == 0)
            first_we.push_back(cyc);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        busy_cnt = 0;
        we_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        first_we.delete();
    endtask

    task automatic load(int p);
        bus.pat_sel = PAT_BITS'(p);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int lim);
        int k = 0;
        while (bus.done !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_row(int r, int lim);
        int k = 0;
        while (!(bus.grid_we === 1'b1 && bus.grid_row == r) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) chk("row_timeout", 0, 1);
    endtask

    task automatic chk_grid(string name, int base);
        int bad = 0;
        for (int r = 0; r < 128; r++)
            if (grid[r] !== exp_word(base + r, 1'b0)) bad++;
        chk(name, bad, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pat_sel = '0;
`ifdef PATTERN_MIRROR_EN
        bus.mirror = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.grid_we, 0);
        chk("rst_addr", bus.rom_addr, 0);
        tick(3);
        rst = 1'b0;
        tick(2);

        clr();
        load(2);
        wait_done(200);
        tick(2);
        chk("basic_writes", we_cnt, 128);
        chk("basic_busy", busy_cnt, 129);
        chk("basic_dones", done_cnt, 1);
        chk("basic_latency", done_cyc - start_cyc, 129);
        chk("basic_row0", grid[0][9:0], 256);
        chk("basic_row127", grid[127][9:0], 383);
        chk_grid("basic_grid", 256);

        clr();
        load(7);
        wait_done(200);
        tick(2);
        chk("b7_first", grid[0][9:0], 896);
        chk("b7_last", grid[127][9:0], 1023);
        chk("b7_addr_hold", bus.rom_addr, 1023);
        chk("b7_writes", we_cnt, 128);

        clr();
        load(1);
        wait_row(40, 200);
        #1;
        bus.pat_sel = 3'd5;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.pat_sel = 3'd6;
        wait_done(200);
        tick(3);
        chk("ign_dones", done_cnt, 1);
        chk("ign_writes", we_cnt, 128);
        chk_grid("ign_grid", 128);

        load(3);
        wait_row(50, 200);
        #1 rst = 1'b1;
        #1;
        chk("mid_we", bus.grid_we, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_addr", bus.rom_addr, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        clr();
        load(0);
        wait_done(200);
        tick(2);
        chk("rel_writes", we_cnt, 128);
        chk_grid("rel_grid", 0);

        clr();
        bus.pat_sel = 3'd4;
        bus.start = 1'b1;
        begin
            int k = 0;
            while (first_we.size() < 2 && k < 400) begin
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        wait_done(200);
        tick(3);
        chk("b2b_loads", first_we.size(), 2);
        if (first_we.size() >= 2)
            chk("b2b_gap", first_we[1] - first_we[0], 130);
        chk("b2b_dones", done_cnt, 2);

`ifdef PATTERN_MIRROR_EN
        bus.mirror = 1'b1;
        load(0);
        bus.mirror = 1'b0;
        wait_row(1, 200);
        chk("mirror_h1", bus.grid_data, {1'b1, 127'b0});
        wait_done(200);
        tick(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
